// File: rtl/ack_pipe_multi.sv
// ack_pipe_multi: multi-channel ack pipe routing each shared bus ack to one pending requester
//   sys_clk  : system clock
//   reset    : asynchronous active-high reset
//   latchd   : per-channel request strobes
//   ack      : shared bus acknowledge
//   latch    : one-hot capture strobe (ack & grant, combinational)
//   pending  : per-channel outstanding counts, channel i at [i*CW +: CW]
//   busy     : any channel has outstanding requests
//   overflow : sticky per-channel dropped-request flags
//   ACK_PIPE_FIXED_PRIORITY_EN : lowest-index-first grant instead of round-robin
module ack_pipe_multi #(
  parameter int CHANNELS = 4,
  parameter int DEPTH = 3,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    latchd,
  input  logic                   ack,
  output logic [CHANNELS-1:0]    latch,
  output logic [CHANNELS*CW-1:0] pending,
  output logic                   busy,
  output logic [CHANNELS-1:0]    overflow
);
  localparam int PW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic [CW-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0] elig, grant;
  logic [PW-1:0] g;
`ifdef ACK_PIPE_FIXED_PRIORITY_EN
  // reverse scan so the lowest eligible index is written last
  always_comb begin
    g = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (elig[i]) g = PW'(i);
  end
`else
  logic [PW-1:0] p;
  // reverse scan from p so the first eligible channel after p is written last
  always_comb begin
    g = '0;
    for (int k = CHANNELS - 1; k >= 0; k--)
      if (elig[(int'(p) + k) % CHANNELS]) g = PW'((int'(p) + k) % CHANNELS);
  end
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) p <= '0;
    else if (|latch) p <= PW'((int'(g) + 1) % CHANNELS);
`endif
  assign grant = (|elig) ? (CHANNELS'(1) << g) : '0;
  assign latch = ack ? grant : '0;
  assign busy = |elig;
  // a full channel still accepts a request when it is retiring one in the same cycle
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (latchd[i] && !latch[i] && cnt[i] != CW'(DEPTH)) cnt[i] <= cnt[i] + CW'(1);
        else if (latch[i] && !latchd[i]) cnt[i] <= cnt[i] - CW'(1);
        if (latchd[i] && !latch[i] && cnt[i] == CW'(DEPTH)) overflow[i] <= 1'b1;
      end
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign elig[i] = |cnt[i];
    assign pending[i*CW +: CW] = cnt[i];
  end
endmodule

// File: tb/tb_ack_pipe_multi.sv
// tb_ack_pipe_multi: directed vector bench for ack_pipe_multi (CHANNELS=4, DEPTH=3)
module tb_ack_pipe_multi;
`ifdef ACK_PIPE_FIXED_PRIORITY_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  typedef struct packed {
    logic [3:0]  ld;
    logic        a;
    logic        r;
    logic [3:0]  el;
    logic [11:0] ep;
    logic        eb;
    logic [3:0]  eo;
  } vec_t;
  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] latchd = '0;
  logic ack = 1'b0;
  logic [3:0] latch;
  logic [11:0] pending;
  logic busy;
  logic [3:0] overflow;
  int total = 0;
  int bad = 0;
  int step_no = 0;
  vec_t tv[$];
  ack_pipe_multi #(.CHANNELS(4), .DEPTH(3)) dut (
    .sys_clk(sys_clk), .reset(reset), .latchd(latchd), .ack(ack),
    .latch(latch), .pending(pending), .busy(busy), .overflow(overflow)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string n, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", n, step_no, act, exp);
    end
  endtask
  task automatic step(input logic [3:0] ld, input logic a, input logic r,
                      input logic [3:0] el, input logic [11:0] ep, input logic eb, input logic [3:0] eo);
    latchd = ld; ack = a; reset = r;
    #1;
    chk("latch", {8'h0, latch}, {8'h0, el});
    chk("pending", pending, ep);
    chk("busy", {11'h0, busy}, {11'h0, eb});
    chk("overflow", {8'h0, overflow}, {8'h0, eo});
    @(posedge sys_clk);
    #1;
    step_no++;
  endtask
  task automatic add(input logic [3:0] ld, input logic a, input logic r,
                     input logic [3:0] el, input logic [11:0] ep, input logic eb, input logic [3:0] eo);
    vec_t v;
    v.ld = ld; v.a = a; v.r = r; v.el = el; v.ep = ep; v.eb = eb; v.eo = eo;
    tv.push_back(v);
  endtask
  initial begin
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0010, 1'b1, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 12'h004, 1'b1, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b0010, 12'h004, 1'b1, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0001, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0001, 1'b0, 1'b0, 4'b0000, 12'h001, 1'b1, 4'b0000);
    add(4'b0001, 1'b0, 1'b0, 4'b0000, 12'h002, 1'b1, 4'b0000);
    add(4'b0001, 1'b0, 1'b0, 4'b0000, 12'h003, 1'b1, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 12'h003, 1'b1, 4'b0001);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 12'h002, 1'b1, 4'b0001);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 12'h001, 1'b1, 4'b0001);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0001);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b1011, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 12'h045, 1'b1, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b0010, 12'h044, 1'b1, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b1000, 12'h040, 1'b1, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0011, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 12'h005, 1'b1, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b0010, 12'h004, 1'b1, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0100, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0100, 1'b0, 1'b0, 4'b0000, 12'h010, 1'b1, 4'b0000);
    add(4'b0100, 1'b0, 1'b0, 4'b0000, 12'h020, 1'b1, 4'b0000);
    add(4'b0100, 1'b1, 1'b0, 4'b0100, 12'h030, 1'b1, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 12'h030, 1'b1, 4'b0000);
    add(4'b1011, 1'b0, 1'b0, 4'b0000, 12'h030, 1'b1, 4'b0000);
    add(4'b1001, 1'b0, 1'b0, 4'b0000, 12'h075, 1'b1, 4'b0000);
    add(4'b1000, 1'b0, 1'b0, 4'b0000, 12'h0B6, 1'b1, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, FP ? 4'b0001 : 4'b1000, 12'h0F6, 1'b1, 4'b0000);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b1000, 1'b1, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    add(4'b0000, 1'b1, 1'b0, 4'b1000, 12'h040, 1'b1, 4'b0000);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    @(posedge sys_clk);
    #1;
    foreach (tv[i]) step(tv[i].ld, tv[i].a, tv[i].r, tv[i].el, tv[i].ep, tv[i].eb, tv[i].eo);
    // channels 0 and 2 two deep each, four back-to-back acks: order depends on arbitration
    step(4'b0101, 1'b0, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    step(4'b0101, 1'b0, 1'b0, 4'b0000, 12'h011, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 1'b0, 4'b0001, 12'h022, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 1'b0, FP ? 4'b0001 : 4'b0100, 12'h021, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 1'b0, FP ? 4'b0100 : 4'b0001, FP ? 12'h020 : 12'h011, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 1'b0, 4'b0100, 12'h010, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 1'b0, 4'b0000, 12'h000, 1'b0, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
